int_wake_timer: RTL and testbench

INT_WAKE_TIMER -- requirements
Module: int_wake_timer

---
 rtl/int_pkg.sv | 31 +++
 rtl/int_tick_gen.sv | 36 +++
 rtl/int_wake_timer.sv | 154 +++++++++++++++
 tb/tb_int_wake_timer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared definitions for the wake timer: FSM states, default timing constants
// and the period clamp helper.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } int_state_e;

    localparam int unsigned SEL_MAX      = 300;
    localparam int unsigned DIV_HI       = 6554;
    localparam int unsigned DIV_LO       = 6553;
    localparam int unsigned PHASE_NUM    = 5;
    // Phases 0..PHASE_HI_NUM-1 use the long divisor, the rest the short one.
    localparam int unsigned PHASE_HI_NUM = 3;

    function automatic logic [8:0] f_sel_eff(input logic [8:0] sel, input int unsigned sel_max);
        logic [8:0] v_res;
        if (sel == 9'd0) begin
            v_res = 9'd1;
        end else if (32'(sel) > sel_max) begin
            v_res = 9'(sel_max);
        end else begin
            v_res = sel;
        end
        return v_res;
    endfunction

endpackage

// File: rtl/int_tick_gen.sv
// Fractional prescaler: three long and two short divisions per five ticks,
// so five ticks span exactly DIV_HI*3 + DIV_LO*2 cycles (one second at default).
module int_tick_gen #(
    parameter int unsigned DIV_HI = int_pkg::DIV_HI,
    parameter int unsigned DIV_LO = int_pkg::DIV_LO
) (
    input  logic clk_32k,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [12:0] r_cnt;
    logic [2:0]  r_phase;
    logic [12:0] w_div_m1;

    assign w_div_m1 = (r_phase < 3'(int_pkg::PHASE_HI_NUM)) ? 13'(DIV_HI - 1) : 13'(DIV_LO - 1);
    assign tick     = en && (r_cnt == w_div_m1);

    // clr outranks en so a stop or a fresh load always starts from phase 0.
    always_ff @(posedge clk_32k) begin
        if (rst || clr) begin
            r_cnt   <= 13'd0;
            r_phase <= 3'd0;
        end else if (en) begin
            if (tick) begin
                r_cnt   <= 13'd0;
                r_phase <= (r_phase == 3'(int_pkg::PHASE_NUM - 1)) ? 3'd0 : r_phase + 3'd1;
            end else begin
                r_cnt   <= r_cnt + 13'd1;
            end
        end
    end

endmodule

// File: rtl/int_wake_timer.sv
// Wake-up timer counting 0.2 s ticks, single-shot or auto-reload, with a one-cycle
// expiry flag. Define INT_TIMER_FRAME_SYNC_EN to defer the flag past a measurement frame.
module int_wake_timer #(
    parameter int unsigned SEL_MAX = int_pkg::SEL_MAX,
    parameter int unsigned DIV_HI  = int_pkg::DIV_HI,
    parameter int unsigned DIV_LO  = int_pkg::DIV_LO
) (
    input  logic       clk_32k,
    input  logic       rst,
    input  logic       rg_timer_on,
    input  logic       rg_timer_mode,
    input  logic [8:0] rg_timer_sel,
    input  logic       frame_on,
    output logic       timer_flag,
    output logic       timer_busy,
    output logic [8:0] timer_remain
);

    import int_pkg::*;

    int_state_e r_state;
    logic [8:0] r_remain;
    logic       r_flag;
    logic       r_busy;
    logic       r_mode;

    logic [8:0] w_sel_eff;
    logic       w_tick;
    logic       w_en;
    logic       w_clr;
    logic       w_last;

    assign w_sel_eff = f_sel_eff(rg_timer_sel, SEL_MAX);
    assign w_last    = w_tick && (r_remain == 9'd1);
    assign w_clr     = !rg_timer_on || (r_state == IDLE);

`ifdef INT_TIMER_FRAME_SYNC_EN
    logic r_hold_auto;
    logic w_hold_to_run;

    assign w_en = rg_timer_on && ((r_state == RUN) || (r_state == HOLD));
    // A single-mode expiry merged on the release cycle must still end in DONE.
    assign w_hold_to_run = r_hold_auto && !(w_last && !r_mode);
`else
    logic w_unused_frame;

    assign w_en           = rg_timer_on && (r_state == RUN);
    assign w_unused_frame = frame_on;
`endif

    int_tick_gen #(
        .DIV_HI (DIV_HI),
        .DIV_LO (DIV_LO)
    ) u_tick_gen (
        .clk_32k (clk_32k),
        .rst     (rst),
        .clr     (w_clr),
        .en      (w_en),
        .tick    (w_tick)
    );

    always_ff @(posedge clk_32k) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remain    <= 9'd0;
            r_flag      <= 1'b0;
            r_busy      <= 1'b0;
            r_mode      <= 1'b0;
`ifdef INT_TIMER_FRAME_SYNC_EN
            r_hold_auto <= 1'b0;
`endif
        end else begin
            r_flag <= 1'b0;
            if (!rg_timer_on) begin
                // Stop wins over a coincident expiry: no flag is raised.
                r_state  <= IDLE;
                r_remain <= 9'd0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_remain <= w_sel_eff;
                        r_mode   <= rg_timer_mode;
                        r_state  <= RUN;
                        r_busy   <= 1'b1;
                    end
                    RUN: begin
                        if (w_last) begin
                            if (r_mode) begin
                                r_remain <= w_sel_eff;
                                r_mode   <= rg_timer_mode;
                            end else begin
                                r_remain <= 9'd0;
                            end
`ifdef INT_TIMER_FRAME_SYNC_EN
                            if (frame_on) begin
                                r_state     <= HOLD;
                                r_hold_auto <= r_mode;
                            end else
`endif
                            begin
                                r_flag <= 1'b1;
                                if (!r_mode) begin
                                    r_state <= DONE;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end else if (w_tick) begin
                            r_remain <= r_remain - 9'd1;
                        end
                    end
`ifdef INT_TIMER_FRAME_SYNC_EN
                    HOLD: begin
                        // The period keeps running; further expiries merge into the pending flag.
                        if (w_last) begin
                            if (r_mode) begin
                                r_remain <= w_sel_eff;
                                r_mode   <= rg_timer_mode;
                            end else begin
                                r_remain    <= 9'd0;
                                r_hold_auto <= 1'b0;
                            end
                        end else if (w_tick && (r_remain != 9'd0)) begin
                            r_remain <= r_remain - 9'd1;
                        end
                        if (!frame_on) begin
                            r_flag <= 1'b1;
                            if (w_hold_to_run) begin
                                r_state <= RUN;
                            end else begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
`endif
                    DONE: begin
                        r_state <= DONE;
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_remain <= 9'd0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign timer_flag   = r_flag;
    assign timer_busy   = r_busy;
    assign timer_remain = r_remain;

endmodule

// File: tb/tb_int_wake_timer.sv
// Directed bench: a default-parameter instance for absolute latency and a
// short-divisor instance (7/5, 31 cycles per 5 ticks) for multi-period sequences.
module tb_int_wake_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       on;
    logic       mode;
    logic       frame;
    logic [8:0] sel;

    logic       flag_s, busy_s, flag_f, busy_f;
    logic [8:0] rem_s, rem_f;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [8:0] sel;
        logic       mode;
        logic [8:0] exp_remain;
    } load_vec_t;

    load_vec_t vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int_wake_timer #(.DIV_HI(7), .DIV_LO(5)) u_dut (
        .clk_32k (clk), .rst (rst), .rg_timer_on (on), .rg_timer_mode (mode),
        .rg_timer_sel (sel), .frame_on (frame),
        .timer_flag (flag_s), .timer_busy (busy_s), .timer_remain (rem_s)
    );

    int_wake_timer u_full (
        .clk_32k (clk), .rst (rst), .rg_timer_on (on), .rg_timer_mode (mode),
        .rg_timer_sel (sel), .frame_on (frame),
        .timer_flag (flag_f), .timer_busy (busy_f), .timer_remain (rem_f)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic o, input logic m, input logic [8:0] s, input logic f);
        on = o; mode = m; sel = s; frame = f;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_flag(input bit full, input int max, output int t);
        t = -1;
        for (int i = 0; i < max; i++) begin
            step(1);
            if ((full ? flag_f : flag_s) === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic count_flags(input bit full, input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if ((full ? flag_f : flag_s) === 1'b1) c++;
        end
    endtask

    task automatic restart();
        drive(1'b0, 1'b0, 9'd0, 1'b0);
        step(2);
    endtask

    task automatic start(input logic m, input logic [8:0] s, input logic f, output int l);
        drive(1'b1, m, s, f);
        step(1);
        l = cyc;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int l, t, t1, t2, t3, c;

        vecs[0] = '{9'd0,   1'b0, 9'd1};
        vecs[1] = '{9'd1,   1'b0, 9'd1};
        vecs[2] = '{9'd7,   1'b1, 9'd7};
        vecs[3] = '{9'd300, 1'b0, 9'd300};
        vecs[4] = '{9'd301, 1'b1, 9'd300};
        vecs[5] = '{9'd511, 1'b0, 9'd300};
        vecs[6] = '{9'd150, 1'b1, 9'd150};

        // Reset holds everything cleared even with the timer enabled.
        rst = 1'b1;
        drive(1'b1, 1'b0, 9'd7, 1'b0);
        step(3);
        check("reset_flag", flag_s, 0);
        check("reset_busy", busy_s, 0);
        check("reset_remain", rem_s, 0);
        check("reset_busy_full", busy_f, 0);
        check("reset_remain_full", rem_f, 0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 9'd0, 1'b0);
        step(2);

        foreach (vecs[i]) begin
            drive(1'b0, 1'b0, 9'd0, 1'b0);
            step(1);
            start(vecs[i].mode, vecs[i].sel, 1'b0, l);
            check("load_remain", rem_s, vecs[i].exp_remain);
            check("load_remain_full", rem_f, vecs[i].exp_remain);
            check("load_busy", busy_s, 1);
            check("load_flag", flag_s, 0);
        end

        // Default divisors: sel=1 single expires 6554 edges after load.
        restart();
        start(1'b0, 9'd1, 1'b0, l);
        wait_flag(1'b1, 7000, t);
        check("single_sel1_latency", t - l, 6554);
        check("single_busy_at_flag", busy_f, 0);
        step(1);
        check("flag_one_cycle", flag_f, 0);
        check("done_remain", rem_f, 0);
        check("done_busy", busy_f, 0);
        count_flags(1'b1, 7000, c);
        check("done_no_refire", c, 0);

        // Auto sel=25: 5 seconds = 155 short-divisor cycles per period.
        restart();
        start(1'b1, 9'd25, 1'b0, l);
        check("auto_load_remain", rem_s, 25);
        step(7);
        check("first_tick_remain", rem_s, 24);
        wait_flag(1'b0, 200, t1);
        check("auto_first_period", t1 - l, 155);
        check("auto_reload_remain", rem_s, 25);
        check("auto_busy", busy_s, 1);
        wait_flag(1'b0, 200, t2);
        check("auto_period_2", t2 - t1, 155);
        wait_flag(1'b0, 200, t3);
        check("auto_period_3", t3 - t2, 155);

        // sel=0 behaves as one tick.
        restart();
        start(1'b0, 9'd0, 1'b0, l);
        wait_flag(1'b0, 50, t);
        check("sel0_latency", t - l, 7);
        step(1);
        check("sel0_done_busy", busy_s, 0);
        check("sel0_done_remain", rem_s, 0);
        count_flags(1'b0, 40, c);
        check("sel0_no_refire", c, 0);

        // Mode is sampled at load only.
        restart();
        start(1'b0, 9'd2, 1'b0, l);
        step(3);
        drive(1'b1, 1'b1, 9'd2, 1'b0);
        wait_flag(1'b0, 50, t);
        check("mode_ignored_latency", t - l, 14);
        step(1);
        check("mode_ignored_done", busy_s, 0);

        // Stop mid-period.
        restart();
        start(1'b1, 9'd3, 1'b0, l);
        step(10);
        drive(1'b0, 1'b1, 9'd3, 1'b0);
        step(1);
        check("stop_busy", busy_s, 0);
        check("stop_remain", rem_s, 0);
        check("stop_flag", flag_s, 0);

        // Stop in the same cycle as an expiry: no flag.
        restart();
        start(1'b1, 9'd1, 1'b0, l);
        step(6);
        drive(1'b0, 1'b1, 9'd1, 1'b0);
        step(1);
        check("stop_at_expiry_flag", flag_s, 0);
        check("stop_at_expiry_remain", rem_s, 0);
        check("stop_at_expiry_busy", busy_s, 0);

        // sel 5 -> 2 mid-period: current period 31 cycles, then 14, then 12.
        restart();
        start(1'b1, 9'd5, 1'b0, l);
        step(10);
        drive(1'b1, 1'b1, 9'd2, 1'b0);
        wait_flag(1'b0, 100, t1);
        check("sel_change_cur_period", t1 - l, 31);
        check("sel_change_reload", rem_s, 2);
        wait_flag(1'b0, 100, t2);
        check("sel_change_next_period", t2 - t1, 14);
        wait_flag(1'b0, 100, t3);
        check("sel_change_phase_period", t3 - t2, 12);

        // Reset mid-period aborts with no flag.
        restart();
        start(1'b1, 9'd3, 1'b0, l);
        step(5);
        rst = 1'b1;
        step(1);
        check("rst_mid_remain", rem_s, 0);
        check("rst_mid_busy", busy_s, 0);
        check("rst_mid_flag", flag_s, 0);
        drive(1'b0, 1'b0, 9'd0, 1'b0);
        step(1);
        rst = 1'b0;
        count_flags(1'b0, 60, c);
        check("rst_mid_no_flag", c, 0);

`ifdef INT_TIMER_FRAME_SYNC_EN
        // Frame held over the expiry and released 100 cycles later.
        restart();
        start(1'b1, 9'd5, 1'b1, l);
        step(20);
        check("frame_run_busy", busy_s, 1);
        count_flags(1'b0, 110, c);
        check("frame_hold_no_flag", c, 0);
        check("frame_hold_busy", busy_s, 1);
        drive(1'b1, 1'b1, 9'd5, 1'b0);
        wait_flag(1'b0, 10, t1);
        check("frame_deferred_flag", t1 - l, 131);
        wait_flag(1'b0, 60, t2);
        check("frame_next_unshifted", t2 - l, 155);
`else
        // Without frame deferral, frame_on has no effect.
        restart();
        start(1'b1, 9'd5, 1'b1, l);
        wait_flag(1'b0, 100, t1);
        check("frame_ignored_first", t1 - l, 31);
        check("frame_ignored_busy", busy_s, 1);
        wait_flag(1'b0, 100, t2);
        check("frame_ignored_next", t2 - t1, 31);
`endif

        drive(1'b0, 1'b0, 9'd0, 1'b0);
        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
